// File: rtl/uart_boot_pkg.sv
// Shared encodings and constants for the UART boot loader and its receiver.
package uart_boot_pkg;

   typedef enum logic [1:0] {
      StLen  = 2'd0,
      StData = 2'd1,
      StDone = 2'd2,
      StErr  = 2'd3
   } boot_state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxBits,
      RxStop
   } rx_state_e;

   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection, centre sampling.
module uart_rx
   import uart_boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e       r_state;
   rx_state_e       w_state_nxt;
   logic [2:0]      r_sync;
   logic [CntW-1:0] r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_ferr;
   logic            w_rxd;
   logic            w_fall;
   logic            w_bit_end;
   logic            w_half;

   // r_sync[1] is the synchronized line; r_sync[2] is its previous value for edge detection.
   assign w_rxd     = r_sync[1];
   assign w_fall    = r_sync[2] & ~r_sync[1];
   assign w_bit_end = (r_cnt == BitEnd);
   assign w_half    = (r_cnt == HalfEnd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RxIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RxIdle:  if (w_fall) w_state_nxt = RxStart;
         RxStart: if (w_half) w_state_nxt = w_rxd ? RxIdle : RxBits;
         RxBits:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = RxStop;
         RxStop:  if (w_bit_end) w_state_nxt = RxIdle;
         default: w_state_nxt = RxIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync    <= 3'b111;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync  <= {r_sync[1:0], rxd};
         r_valid <= (r_state == RxStop) && w_bit_end && w_rxd;
         r_ferr  <= (r_state == RxStop) && w_bit_end && !w_rxd;
         if ((r_state == RxIdle) || (w_state_nxt != r_state) || w_bit_end) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == RxIdle) begin
            r_bit_idx <= '0;
         end else if ((r_state == RxBits) && w_bit_end) begin
            r_data    <= {w_rxd, r_data[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
         end
      end
   end

   assign rx_valid = r_valid;
   assign rx_byte  = r_data;
   assign rx_ferr  = r_ferr;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed big-endian image over UART, writes it to InstMem, then
// releases the CPU core from reset.
module uart_boot_loader
   import uart_boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned MAX_WORDS    = 1024,
   parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rxd,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_rst,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] word_cnt
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CLKS);

   boot_state_e     r_state;
   boot_state_e     w_state_nxt;
   logic            w_rx_valid;
   logic [7:0]      w_rx_byte;
   logic            w_rx_ferr;
   logic [23:0]     r_shift;
   logic [1:0]      r_byte_idx;
   logic [31:0]     w_word;
   logic            w_word_done;
   logic [15:0]     r_n;
   logic [15:0]     r_cnt;
   logic            r_we;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic            r_fin;
   logic            r_started;
   logic [TmoW-1:0] r_tmo;
   logic            w_tmo;
   logic            w_active;
   logic            w_abort;
   logic            w_wr;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rxd     (uart_rxd),
      .rx_valid(w_rx_valid),
      .rx_byte (w_rx_byte),
      .rx_ferr (w_rx_ferr)
   );

   assign w_word      = {r_shift, w_rx_byte};
   assign w_word_done = w_rx_valid && (r_byte_idx == 2'(WORD_BYTES - 1));
   assign w_active    = (r_state == StLen) || (r_state == StData);
   assign w_tmo       = (r_tmo == TmoMax);
   assign w_abort     = w_active && (w_rx_ferr || w_tmo);
   assign w_wr        = (r_state == StData) && w_word_done && !w_abort && !r_fin;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StLen;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StLen: begin
            if (w_abort) begin
               w_state_nxt = StErr;
            end else if (w_word_done) begin
               if (w_word == '0) begin
                  w_state_nxt = StDone;
               end else if (w_word > 32'(MAX_WORDS)) begin
                  w_state_nxt = StErr;
               end else begin
                  w_state_nxt = StData;
               end
            end
         end
         StData: begin
            if (w_abort) begin
               w_state_nxt = StErr;
            end else if (r_fin) begin
               w_state_nxt = StDone;
            end
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_comb begin
      cpu_rst   = 1'b1;
      load_done = 1'b0;
      load_err  = 1'b0;
      unique case (r_state)
         StDone: begin
            cpu_rst   = 1'b0;
            load_done = 1'b1;
         end
         StErr:   load_err = 1'b1;
         default: cpu_rst = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= BASE_ADDR;
         r_wdata    <= '0;
         r_fin      <= 1'b0;
         r_started  <= 1'b0;
         r_tmo      <= '0;
      end else begin
         if (w_rx_valid) begin
            r_shift    <= {r_shift[15:0], w_rx_byte};
            r_byte_idx <= r_byte_idx + 1'b1;
            r_started  <= 1'b1;
         end
         if ((r_state == StLen) && w_word_done) begin
            r_n <= w_word[15:0];
         end
         r_we <= w_wr;
         if (w_wr) begin
            r_wdata <= w_word;
            r_cnt   <= r_cnt + 1'b1;
         end
         if (r_we) begin
            r_addr <= r_addr + 32'(WORD_BYTES);
         end
         // Registered completion flag gives the two-clock write-to-release latency.
         r_fin <= r_we && (r_cnt == r_n);
         if (w_rx_valid || !r_started || !w_active) begin
            r_tmo <= '0;
         end else if (!w_tmo) begin
            r_tmo <= r_tmo + 1'b1;
         end
      end
   end

   assign im_we    = r_we;
   assign im_addr  = r_addr;
   assign im_wdata = r_wdata;
   assign word_cnt = r_cnt;

endmodule
